// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan driver.
package seg_pkg;

    localparam logic [7:0] BLANK_CHAR = 8'h00;

    typedef enum logic [1:0] {IDLE, LOAD, SHOW} seg_state_t;

    localparam int unsigned DIGITS_DEF      = 8;
    localparam int unsigned MSG_DEPTH_DEF   = 16;
    localparam int unsigned REFRESH_DIV_DEF = 100000;
    localparam int unsigned SCROLL_DIV_DEF  = 25000000;

endpackage

// File: rtl/seg_scan_driver_if.sv
// Character write port of the scan driver: valid/ready handshake with an end-of-message flag.
interface seg_scan_driver_if;

    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] wr_char;
    logic       wr_last;

    modport master (output wr_valid, output wr_char, output wr_last, input wr_ready);
    modport slave  (input wr_valid, input wr_char, input wr_last, output wr_ready);

endinterface

// File: rtl/seg_msg_buffer.sv
// Message register file: one synchronous write port, one combinational read port that
// returns BLANK_CHAR for any index at or beyond the current message length.
module seg_msg_buffer
    import seg_pkg::*;
#(
    parameter int unsigned MSG_DEPTH = 16,
    parameter int unsigned AW        = 4,
    parameter int unsigned IW        = 5
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [IW-1:0] raddr,
    input  logic [IW-1:0] len,
    output logic [7:0]    rdata
);

    logic [7:0] mem [MSG_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = (raddr < len) ? mem[raddr[AW-1:0]] : BLANK_CHAR;

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed, scrolling seven-segment scan driver fed by a valid/ready message port.
// Scrolling is built only when SEG_SCROLL_EN is defined; otherwise the display is static.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int unsigned DIGITS      = DIGITS_DEF,
    parameter int unsigned MSG_DEPTH   = MSG_DEPTH_DEF,
    parameter int unsigned REFRESH_DIV = REFRESH_DIV_DEF,
    parameter int unsigned SCROLL_DIV  = SCROLL_DIV_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    seg_scan_driver_if.slave  wr,
    input  logic              clear,
    output logic [7:0]        char_out,
    output logic [DIGITS-1:0] anode_n,
    output logic              showing
);

    localparam int unsigned LW  = $clog2(MSG_DEPTH + 1);
    localparam int unsigned AW  = $clog2(MSG_DEPTH);
    localparam int unsigned SW  = $clog2(DIGITS);
    localparam int unsigned RW  = $clog2(2 * (MSG_DEPTH + DIGITS));
    localparam int unsigned RCW = $clog2(REFRESH_DIV);

    if (DIGITS < 2 || MSG_DEPTH < 2 || REFRESH_DIV < 2 || SCROLL_DIV < 2) begin : g_param_check
        $error("seg_scan_driver: parameter below minimum of 2");
    end

    seg_state_t        state_q, state_d;
    logic [LW-1:0]     len_q, len_d;
    logic [SW-1:0]     s_q, s_d;
    logic [RCW-1:0]    rcnt_q, rcnt_d;
    logic [RW-1:0]     offset_d;
    logic [RW-1:0]     ring_len, pos_sum, pos;
    logic [7:0]        rd_data, char_sel;
    logic [DIGITS-1:0] onehot;
    logic              rtick, wr_fire, show_d, slot_load, ready_q;

    assign wr_fire     = wr.wr_valid && ready_q && !clear;
    assign wr.wr_ready = ready_q;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        s_d     = s_q;
        rcnt_d  = rcnt_q;
        rtick   = 1'b0;
        unique case (state_q)
            IDLE, LOAD: begin
                // Filling the buffer ends the message even without wr_last.
                if (wr_fire) begin
                    len_d   = len_q + LW'(1);
                    state_d = (wr.wr_last || len_d == LW'(MSG_DEPTH)) ? SHOW : LOAD;
                end
            end
            SHOW: begin
                rtick  = (rcnt_q == RCW'(REFRESH_DIV - 1));
                rcnt_d = rtick ? '0 : rcnt_q + RCW'(1);
                if (rtick) begin
                    s_d = (s_q == SW'(DIGITS - 1)) ? '0 : s_q + SW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (clear) begin
            state_d = IDLE;
            len_d   = '0;
            s_d     = '0;
            rcnt_d  = '0;
        end
    end

`ifdef SEG_SCROLL_EN
    localparam int unsigned SCW = $clog2(SCROLL_DIV);

    logic [RW-1:0]  offset_q;
    logic [SCW-1:0] scnt_q, scnt_d;

    always_comb begin
        scnt_d   = '0;
        offset_d = offset_q;
        if (clear) begin
            offset_d = '0;
        end else if (state_q == SHOW) begin
            scnt_d = (scnt_q == SCW'(SCROLL_DIV - 1)) ? '0 : scnt_q + SCW'(1);
            if (scnt_q == SCW'(SCROLL_DIV - 1)) begin
                offset_d = (offset_q == RW'(len_q) + RW'(DIGITS) - RW'(1)) ? '0
                                                                           : offset_q + RW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            offset_q <= '0;
            scnt_q   <= '0;
        end else begin
            offset_q <= offset_d;
            scnt_q   <= scnt_d;
        end
    end
`else
    assign offset_d = '0;
`endif

    // Look up the character for the next slot; pos_sum < 2*ring_len so one subtraction wraps it.
    always_comb begin
        ring_len  = RW'(len_d) + RW'(DIGITS);
        pos_sum   = offset_d + (RW'(DIGITS - 1) - RW'(s_d));
        pos       = (pos_sum >= ring_len) ? pos_sum - ring_len : pos_sum;
        char_sel  = (wr_fire && pos == RW'(len_q)) ? wr.wr_char : rd_data;
        onehot    = '0;
        onehot[s_d] = 1'b1;
        show_d    = (state_d == SHOW);
        slot_load = show_d && ((state_q != SHOW) || rtick);
    end

    seg_msg_buffer #(
        .MSG_DEPTH (MSG_DEPTH),
        .AW        (AW),
        .IW        (RW)
    ) u_buf (
        .clk   (clk),
        .we    (wr_fire),
        .waddr (len_q[AW-1:0]),
        .wdata (wr.wr_char),
        .raddr (pos),
        .len   (RW'(len_q)),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            len_q    <= '0;
            s_q      <= '0;
            rcnt_q   <= '0;
            ready_q  <= 1'b1;
            showing  <= 1'b0;
            anode_n  <= '1;
            char_out <= BLANK_CHAR;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            s_q     <= s_d;
            rcnt_q  <= rcnt_d;
            ready_q <= !show_d;
            showing <= show_d;
            if (!show_d) begin
                anode_n  <= '1;
                char_out <= BLANK_CHAR;
            end else if (slot_load) begin
                anode_n  <= ~onehot;
                char_out <= char_sel;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver: a message/ring model checked every cycle plus
// directed literal checks. Honours SEG_SCROLL_EN the same way as the design.
module tb_seg_scan_driver;

    localparam int DIGITS      = 4;
    localparam int MSG_DEPTH   = 16;
    localparam int REFRESH_DIV = 4;
    localparam int SCROLL_DIV  = 32;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0;
    logic [7:0] char_out;
    logic [3:0] anode_n;
    logic       showing;
    logic       cmp_en = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    seg_scan_driver_if wr_if ();

    seg_scan_driver #(
        .DIGITS      (DIGITS),
        .MSG_DEPTH   (MSG_DEPTH),
        .REFRESH_DIV (REFRESH_DIV),
        .SCROLL_DIV  (SCROLL_DIV)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr       (wr_if),
        .clear    (clear),
        .char_out (char_out),
        .anode_n  (anode_n),
        .showing  (showing)
    );

    always #5 clk = ~clk;

    // Model: mode 0 idle, 1 load, 2 show; m_t counts cycles since entering show.
    int         m_mode = 0;
    int         m_len  = 0;
    int         m_t    = 0;
    logic [7:0] m_msg [MSG_DEPTH];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode <= 0;
            m_len  <= 0;
            m_t    <= 0;
        end else if (clear) begin
            m_mode <= 0;
            m_len  <= 0;
            m_t    <= 0;
        end else if (m_mode != 2) begin
            if (wr_if.wr_valid) begin
                m_msg[m_len] <= wr_if.wr_char;
                m_len        <= m_len + 1;
                m_mode       <= (wr_if.wr_last || m_len + 1 == MSG_DEPTH) ? 2 : 1;
                m_t          <= 0;
            end
        end else begin
            m_t <= m_t + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (time %0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && cmp_en) begin
            int ring, k, s, off, idx;
            logic [3:0] exp_an;
            logic [7:0] exp_ch;
            exp_an = 4'b1111;
            exp_ch = 8'h00;
            if (m_mode == 2) begin
                ring = m_len + DIGITS;
                k    = m_t / REFRESH_DIV;
                s    = k % DIGITS;
`ifdef SEG_SCROLL_EN
                off  = ((k * REFRESH_DIV) / SCROLL_DIV) % ring;
`else
                off  = 0;
`endif
                idx    = (off + DIGITS - 1 - s) % ring;
                exp_ch = (idx < m_len) ? m_msg[idx] : 8'h00;
                exp_an = 4'b1111 ^ (4'b0001 << s);
            end
            check("cyc_anode_n", 32'(anode_n), 32'(exp_an));
            check("cyc_char_out", 32'(char_out), 32'(exp_ch));
            check("cyc_wr_ready", 32'(wr_if.wr_ready), 32'(m_mode != 2));
            check("cyc_showing", 32'(showing), 32'(m_mode == 2));
        end
    end

    task automatic write_char(input logic [7:0] c, input logic last);
        wr_if.wr_valid = 1'b1;
        wr_if.wr_char  = c;
        wr_if.wr_last  = last;
        @(posedge clk);
        #1;
        wr_if.wr_valid = 1'b0;
        wr_if.wr_last  = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    task automatic wait_t(input int target);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(m_mode == 2 && m_t == target) && n < 2000);
        if (n >= 2000) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_t: show cycle %0d not reached, got %0d", target, m_t);
        end
    endtask

    task automatic check_digit(input string name, input int digit, input logic [7:0] ch);
        logic [3:0] exp_an;
        exp_an = 4'b1111 ^ (4'b0001 << digit);
        check({name, "_an"}, 32'(anode_n), 32'(exp_an));
        check({name, "_ch"}, 32'(char_out), 32'(ch));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        wr_if.wr_valid = 1'b0;
        wr_if.wr_char  = 8'h00;
        wr_if.wr_last  = 1'b0;
        #22 rst_n = 1'b1;
        @(negedge clk);
        check("rst_anode_n", 32'(anode_n), 32'hF);
        check("rst_char_out", 32'(char_out), 32'h00);
        check("rst_wr_ready", 32'(wr_if.wr_ready), 32'h1);
        check("rst_showing", 32'(showing), 32'h0);
        cmp_en = 1'b1;

        // Writes without wr_last keep the display dark.
        for (int i = 0; i < 3; i++) begin
            write_char(8'h41 + 8'(i), 1'b0);
            @(negedge clk);
            check("load_anode_off", 32'(anode_n), 32'hF);
        end
        do_clear();

        // "hello"
        write_char(8'h68, 1'b0);
        write_char(8'h65, 1'b0);
        write_char(8'h6C, 1'b0);
        write_char(8'h6C, 1'b0);
        write_char(8'h6F, 1'b1);
        @(negedge clk);
        check("hello_showing", 32'(showing), 32'h1);
        check_digit("hello_slot0", 0, 8'h6C);
        repeat (4) @(negedge clk);
        check_digit("hello_slot1", 1, 8'h6C);
        do_clear();
        @(negedge clk);
        check("clear_show_anode", 32'(anode_n), 32'hF);

        // "hi": ring length 6
        write_char(8'h68, 1'b0);
        write_char(8'h69, 1'b1);
`ifdef SEG_SCROLL_EN
        wait_t(64);  check_digit("hi_off2_d0", 0, 8'h00);
        wait_t(68);  check_digit("hi_off2_d1", 1, 8'h00);
        wait_t(72);  check_digit("hi_off2_d2", 2, 8'h00);
        wait_t(76);  check_digit("hi_off2_d3", 3, 8'h00);
        wait_t(164); check_digit("hi_off5_d1", 1, 8'h69);
        wait_t(168); check_digit("hi_off5_d2", 2, 8'h68);
        wait_t(172); check_digit("hi_off5_d3", 3, 8'h00);
        wait_t(204); check_digit("hi_wrap_d3", 3, 8'h68);
`else
        wait_t(4);   check_digit("hi_static_d1", 1, 8'h00);
        wait_t(8);   check_digit("hi_static_d2", 2, 8'h69);
        wait_t(12);  check_digit("hi_static_d3", 3, 8'h68);
        wait_t(70);
`endif
        do_clear();

        // Overflow: 16 characters without wr_last end the message.
        for (int i = 0; i < MSG_DEPTH; i++) write_char(8'h41 + 8'(i), 1'b0);
        @(negedge clk);
        check("ovf_showing", 32'(showing), 32'h1);
        check("ovf_wr_ready", 32'(wr_if.wr_ready), 32'h0);
        check_digit("ovf_slot0", 0, 8'h44);
        write_char(8'h51, 1'b1);
        @(negedge clk);
        check("ovf_17th_ready", 32'(wr_if.wr_ready), 32'h0);
        check_digit("ovf_17th_slot0", 0, 8'h44);
        do_clear();

        // clear beats a simultaneous write.
        write_char(8'h61, 1'b0);
        write_char(8'h62, 1'b0);
        clear = 1'b1;
        write_char(8'h63, 1'b1);
        clear = 1'b0;
        @(negedge clk);
        check("clrpri_wr_ready", 32'(wr_if.wr_ready), 32'h1);
        check("clrpri_showing", 32'(showing), 32'h0);
        write_char(8'h7A, 1'b1);
        wait_t(0);  check_digit("clrpri_d0", 0, 8'h00);
        wait_t(12); check_digit("clrpri_d3", 3, 8'h7A);

        // Asynchronous reset between clock edges.
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_anode_n", 32'(anode_n), 32'hF);
        check("arst_char_out", 32'(char_out), 32'h00);
        check("arst_wr_ready", 32'(wr_if.wr_ready), 32'h1);
        check("arst_showing", 32'(showing), 32'h0);
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Time-multiplexed driver for the 8-digit seven-segment display: it accepts a character message over a valid/ready write port, then scans it across the digits one at a time and scrolls it. It sits upstream of the character-to-segment decoder. It presents one character code per scan slot on `char_out` for the decoder and drives the matching active-low anode.

## Interface
- `DIGITS`, 8: number of display digits (≥2).
- `MSG_DEPTH`, 16: maximum message length in characters (≥2).
- `REFRESH_DIV`, 100000: clock cycles per digit scan slot (≥2).
- `SCROLL_DIV`, 25000000: clock cycles per one-character scroll step (≥2).

Ports:
- `clk`  in  1: single clock; all logic on its rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `wr_valid`  in  1: character write request.
- `wr_ready`  out  1: write accepted when `wr_valid && wr_ready`.
- `wr_char`  in  8: ASCII character code.
- `wr_last`  in  1: marks the final character of the message.
- `clear`  in  1: discard the message and return to idle.
- `char_out`  out  8: character code for the current digit, fed to the decoder.
- `anode_n`  out  DIGITS: one-hot-low digit enable; bit k drives digit k, digit 0 is rightmost.
- `showing`  out  1: high while in SHOW.

## Operation
- Blank code is 8'h00; the decoder renders it as all segments off.
- States and transitions:
  - IDLE: `wr_ready`=1, `anode_n` all 1, `char_out`=8'h00. An accepted write stores the character at index 0 and sets `len`=1. The next state is LOAD, or SHOW if `wr_last` is set.
  - LOAD: `wr_ready`=1 and the display stays off. Each accepted write stores the character at index `len` and increments `len`. The state moves to SHOW on an accepted write with `wr_last`=1, or on the write that brings `len` to MSG_DEPTH, which is terminated implicitly.
  - SHOW: `wr_ready`=0 and `showing`=1. Scanning and scrolling run.
- `clear`, sampled in any state, moves to IDLE on the next edge. It zeroes `len`, the scroll offset and the counters. When `clear` and an accepted write occur in the same cycle, `clear` wins and the write is discarded.
- Virtual ring of length R = `len` + DIGITS: the message followed by DIGITS blanks.
- Scan: the slot index `s` advances 0,1,…,DIGITS-1 and wraps to 0, one step per refresh tick. Digit `s` shows ring[(offset + DIGITS-1-s) mod R], so the leftmost digit holds the character at `offset`.
- Scroll: `offset` increments on each scroll tick and wraps from R-1 to 0.
- Writes attempted in SHOW are not accepted. The message buffer is written only in IDLE and LOAD.

## Timing
- All outputs are registered. Reset values: `wr_ready`=1, `anode_n`=all 1, `char_out`=8'h00, `showing`=0. Internal reset values: state IDLE, `len`=0, `offset`=0, `s`=0, both counters 0.
- Refresh counter counts 0..REFRESH_DIV-1 in SHOW only; the tick fires at REFRESH_DIV-1. The scroll counter behaves the same way with SCROLL_DIV.
- SHOW entry: on the first SHOW cycle, `anode_n` selects digit 0 with the matching `char_out` (offset 0). Each later slot change appears one cycle after its tick. `anode_n` and `char_out` always change on the same edge.
- When a scroll tick and a refresh tick coincide, the new slot uses the new offset.
- The state reaches IDLE one cycle after `clear` is asserted. The first cycle in IDLE shows `anode_n` all 1.
- `rst_n` low mid-message forces the reset values immediately (asynchronous) and discards the message.

## Configuration
- `SEG_SCROLL_EN` defined: scrolling as described above.
- `SEG_SCROLL_EN` not defined: the scroll counter is removed and `offset` is fixed at 0, giving a static left-aligned display of the first DIGITS ring entries. Messages longer than DIGITS are truncated on screen.

## Structure
- Shared package `seg_pkg`:
  - `BLANK_CHAR` = 8'h00.
  - State enum `seg_state_t` {IDLE, LOAD, SHOW}.
  - Default divider constants.
- Sub-module `seg_msg_buffer`: MSG_DEPTH×8 register file with one synchronous write port and one combinational read port. A read at index ≥ `len` returns BLANK_CHAR.
- The character-to-segment decoder is instantiated by the parent, not inside this block.

## Test plan
All scenarios use DIGITS=4, MSG_DEPTH=16, REFRESH_DIV=4, SCROLL_DIV=32.
- Reset/idle: after reset `anode_n`=4'b1111, `char_out`=8'h00, `wr_ready`=1. Toggling `wr_valid` with `wr_last`=0 keeps the display off.
- Load "hello" ("h","e","l","l","o", `wr_last` on "o"): `showing` rises the cycle after "o". First slot is `anode_n`=4'b1110 with `char_out`=8'h6C ("l", ring[3]). Four cycles later `anode_n`=4'b1101 with 8'h6C ("l", ring[2]).
- Scroll wrap with "hi" (R=6): `offset` steps 0→5→0 every 32 cycles. At offset 2 all four digits show 8'h00. At offset 5, leftmost digit 3 is blank and digits 2 and 1 show 8'h68 and 8'h69 ("h","i").
- Overflow: write 16 characters with `wr_last`=0. SHOW is entered after the 16th, and a 17th `wr_valid` sees `wr_ready`=0.
- Clear priority: in LOAD, assert `clear` and an accepted write in the same cycle. Next cycle is IDLE with `len`=0 and the character is discarded. `clear` during SHOW turns `anode_n` to 4'b1111 one cycle later.
- Async reset mid-SHOW: pulse `rst_n` low between edges. Outputs return to their reset values without a clock edge.
